// File: rtl/control_module.sv
// ---------------------------------------------------------------------------
// control_module
//
// Transmission sequencer for the optical link front-end. After reset it arms
// the photodetector, waits for the detection flag and then runs one or more
// transmission passes. Each pass is an optional 8-cycle preamble followed by
// one cycle per data bank. The banks come either from a single selected bank
// or from a sequence of up to nine bank indices. Passes are separated by a
// programmable gap, and the whole transmission is repeated a programmable
// number of times.
//
// Ports
//   MAIN_CLK_i                        system clock, rising edge
//   MAIN_RST_i                        asynchronous active-high reset
//   FLAG_POR_i                        power-on-reset flag, synchronous return to IDLE
//   ADD_PD_OUT_OUTFLAG_i              photodetector detection flag (level)
//   ADD_PD_STA_OUT_READY_i            photodetector ready, mirrored on LED[1]
//   CFREG_DATA_BANK_REPEAT_i [3:0]    extra passes after the first one
//   CFREG_DATA_BANK_SELECT_i [3:0]    bank index used in single mode
//   CFREG_DATA_BANK_SEQUENCE_i [35:0] nine bank indices, slot 0 in [35:32]
//   CFREG_DATA_SEL_SINGLE_SEQUENCE_i  1 = single bank, 0 = sequence
//   CFREG_DELAY_DATA_BANK_REPEAT_i [4:0] gap length between passes
//   CFREG_FORCE_STATE_FSM_i [7:0]     one-hot state override, 0 = normal
//   CFREG_PREAMB_i                    preamble before the first pass
//   CFREG_REPEAT_WITH_PREAMB_i        preamble before every repeated pass
//   ANA_PD_EN_o                       photodetector enable
//   ANA_MOD_EN_o                      modulator enable
//   ANA_FREQ_DIVIDER_EN_o             frequency divider enable
//   ANA_INTERFACE_IN_MODSELECT_o      0 = preamble pattern, 1 = data
//   ANA_MUX_EN_o                      analog mux enable
//   DATA_REG_MUX_EN_o                 data-register mux enable
//   DATA_REG_MUX_SEL_DATA_o [8:0]     one-hot bank select
//   PORT_STA_LED_o [2:0]              [2] transmitting, [1] PD ready, [0] waiting
// ---------------------------------------------------------------------------
module control_module (
    input  logic        MAIN_CLK_i,
    input  logic        MAIN_RST_i,
    input  logic        FLAG_POR_i,
    input  logic        ADD_PD_OUT_OUTFLAG_i,
    input  logic        ADD_PD_STA_OUT_READY_i,
    input  logic [3:0]  CFREG_DATA_BANK_REPEAT_i,
    input  logic [3:0]  CFREG_DATA_BANK_SELECT_i,
    input  logic [35:0] CFREG_DATA_BANK_SEQUENCE_i,
    input  logic        CFREG_DATA_SEL_SINGLE_SEQUENCE_i,
    input  logic [4:0]  CFREG_DELAY_DATA_BANK_REPEAT_i,
    input  logic [7:0]  CFREG_FORCE_STATE_FSM_i,
    input  logic        CFREG_PREAMB_i,
    input  logic        CFREG_REPEAT_WITH_PREAMB_i,
    output logic        ANA_PD_EN_o,
    output logic        ANA_MOD_EN_o,
    output logic        ANA_FREQ_DIVIDER_EN_o,
    output logic        ANA_INTERFACE_IN_MODSELECT_o,
    output logic        ANA_MUX_EN_o,
    output logic        DATA_REG_MUX_EN_o,
    output logic [8:0]  DATA_REG_MUX_SEL_DATA_o,
    output logic [2:0]  PORT_STA_LED_o
);

    // One-hot state encoding; the force register writes these codes directly.
    typedef enum logic [5:0] {
        IDLE    = 6'h01,
        PD_WAIT = 6'h02,
        PREAMB  = 6'h04,
        SEND    = 6'h08,
        GAP     = 6'h10,
        DONE    = 6'h20
    } stateT;

    localparam logic [4:0] PREAMB_LAST = 5'd7;
    localparam logic [3:0] LAST_BANK   = 4'd8;

    stateT       state_q;
    stateT       state_d;
    logic [3:0]  slot_q;
    logic [3:0]  slot_d;
    logic [3:0]  passCnt_q;
    logic [3:0]  passCnt_d;
    logic [4:0]  timer_q;
    logic [4:0]  timer_d;
    logic        ready_q;
    logic        runEn_q;

    logic        forceValid;
    logic [3:0]  curBank;
    logic [3:0]  nextBank;
    logic        curValid;
    logic        nextValid;
    logic        passEnd;
    logic        morePasses;
    logic        preambOnRepeat;
    logic [4:0]  timerInc;

    // Picks nibble k of the sequence word, slot 0 being the top nibble.
    // Slots past the ninth read as a terminator so the last slot always
    // closes the pass.
    function automatic logic [3:0] seqNibble(input logic [35:0] seq,
                                             input logic [3:0]  k);
        logic [3:0] nib;
        nib = 4'hF;
        case (k)
            4'd0:    nib = seq[35:32];
            4'd1:    nib = seq[31:28];
            4'd2:    nib = seq[27:24];
            4'd3:    nib = seq[23:20];
            4'd4:    nib = seq[19:16];
            4'd5:    nib = seq[15:12];
            4'd6:    nib = seq[11:8];
            4'd7:    nib = seq[7:4];
            4'd8:    nib = seq[3:0];
            default: nib = 4'hF;
        endcase
        return nib;
    endfunction

    // Slot bookkeeping. The current bank is what SEND shows this cycle; the
    // next bank is looked at ahead of time so that a terminator nibble ends
    // the pass without spending a cycle on it. A pass also ends when the
    // current bank itself is out of range (empty pass) or in single mode.
    always_comb begin
        forceValid     = (CFREG_FORCE_STATE_FSM_i[7:6] == 2'b00) &&
                         $onehot(CFREG_FORCE_STATE_FSM_i[5:0]);
        curBank        = CFREG_DATA_SEL_SINGLE_SEQUENCE_i ?
                         CFREG_DATA_BANK_SELECT_i :
                         seqNibble(CFREG_DATA_BANK_SEQUENCE_i, slot_q);
        nextBank       = seqNibble(CFREG_DATA_BANK_SEQUENCE_i, slot_q + 4'd1);
        curValid       = (curBank <= LAST_BANK);
        nextValid      = (nextBank <= LAST_BANK);
        passEnd        = CFREG_DATA_SEL_SINGLE_SEQUENCE_i || !curValid || !nextValid;
        morePasses     = (passCnt_q < CFREG_DATA_BANK_REPEAT_i);
        preambOnRepeat = CFREG_PREAMB_i && CFREG_REPEAT_WITH_PREAMB_i;
        timerInc       = timer_q + 5'd1;
    end

    // Next-state logic. The power-on flag beats the force register, which
    // beats the normal flow. Both the power-on flag and forcing keep all
    // counters at zero so the FSM restarts cleanly from whatever state it
    // lands in. The timer is shared between the preamble and the gap, which
    // never overlap.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        passCnt_d = passCnt_q;
        timer_d   = timer_q;
        if (FLAG_POR_i) begin
            state_d   = IDLE;
            slot_d    = '0;
            passCnt_d = '0;
            timer_d   = '0;
        end else if (forceValid) begin
            state_d   = stateT'(CFREG_FORCE_STATE_FSM_i[5:0]);
            slot_d    = '0;
            passCnt_d = '0;
            timer_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    slot_d    = '0;
                    passCnt_d = '0;
                    timer_d   = '0;
                    if (runEn_q) begin
                        state_d = PD_WAIT;
                    end
                end
                PD_WAIT: begin
                    slot_d    = '0;
                    passCnt_d = '0;
                    timer_d   = '0;
                    if (ADD_PD_OUT_OUTFLAG_i) begin
                        state_d = CFREG_PREAMB_i ? PREAMB : SEND;
                    end
                end
                PREAMB: begin
                    if (timer_q >= PREAMB_LAST) begin
                        timer_d = '0;
                        state_d = SEND;
                    end else begin
                        timer_d = timerInc;
                    end
                end
                SEND: begin
                    timer_d = '0;
                    if (!passEnd) begin
                        slot_d = slot_q + 4'd1;
                    end else begin
                        slot_d = '0;
                        if (morePasses) begin
                            passCnt_d = passCnt_q + 4'd1;
                            if (CFREG_DELAY_DATA_BANK_REPEAT_i != 5'd0) begin
                                state_d = GAP;
                            end else begin
                                state_d = preambOnRepeat ? PREAMB : SEND;
                            end
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                GAP: begin
                    if (timerInc >= CFREG_DELAY_DATA_BANK_REPEAT_i) begin
                        timer_d = '0;
                        state_d = preambOnRepeat ? PREAMB : SEND;
                    end else begin
                        timer_d = timerInc;
                    end
                end
                DONE: begin
                    slot_d    = '0;
                    passCnt_d = '0;
                    timer_d   = '0;
                    if (!ADD_PD_OUT_OUTFLAG_i) begin
                        state_d = PD_WAIT;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    slot_d    = '0;
                    passCnt_d = '0;
                    timer_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers. runEn_q holds IDLE for the first clock
    // after reset release so the rest of the front-end sees one settled
    // cycle before the photodetector is armed. The ready flag is simply
    // delayed by one clock for the status LED.
    always_ff @(posedge MAIN_CLK_i or posedge MAIN_RST_i) begin
        if (MAIN_RST_i) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            passCnt_q <= '0;
            timer_q   <= '0;
            ready_q   <= 1'b0;
            runEn_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            passCnt_q <= passCnt_d;
            timer_q   <= timer_d;
            ready_q   <= ADD_PD_STA_OUT_READY_i;
            runEn_q   <= 1'b1;
        end
    end

    // Moore output decode from the registered state and slot. Because it
    // only depends on registers, asserting reset drives every output low
    // without waiting for a clock. In SEND an out-of-range bank still keeps
    // the modulator in data mode but blanks both mux enables and the select.
    always_comb begin
        ANA_PD_EN_o                  = 1'b0;
        ANA_MOD_EN_o                 = 1'b0;
        ANA_FREQ_DIVIDER_EN_o        = 1'b0;
        ANA_INTERFACE_IN_MODSELECT_o = 1'b0;
        ANA_MUX_EN_o                 = 1'b0;
        DATA_REG_MUX_EN_o            = 1'b0;
        DATA_REG_MUX_SEL_DATA_o      = '0;
        PORT_STA_LED_o               = {1'b0, ready_q, 1'b0};
        case (state_q)
            PD_WAIT: begin
                ANA_PD_EN_o       = 1'b1;
                PORT_STA_LED_o[0] = 1'b1;
            end
            PREAMB: begin
                ANA_PD_EN_o           = 1'b1;
                ANA_MOD_EN_o          = 1'b1;
                ANA_FREQ_DIVIDER_EN_o = 1'b1;
                PORT_STA_LED_o[2]     = 1'b1;
            end
            SEND: begin
                ANA_PD_EN_o                  = 1'b1;
                ANA_MOD_EN_o                 = 1'b1;
                ANA_FREQ_DIVIDER_EN_o        = 1'b1;
                ANA_INTERFACE_IN_MODSELECT_o = 1'b1;
                PORT_STA_LED_o[2]            = 1'b1;
                if (curValid) begin
                    ANA_MUX_EN_o            = 1'b1;
                    DATA_REG_MUX_EN_o       = 1'b1;
                    DATA_REG_MUX_SEL_DATA_o = 9'd1 << curBank;
                end
            end
            GAP: begin
                ANA_PD_EN_o       = 1'b1;
                PORT_STA_LED_o[2] = 1'b1;
            end
            DONE: begin
                ANA_PD_EN_o = 1'b1;
            end
            default: begin
                ANA_PD_EN_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_module.sv
// ---------------------------------------------------------------------------
// tb_control_module
//
// Self-checking bench for control_module. A behavioural model turns the
// current configuration into the expected list of per-cycle output words
// (preamble cycles, one word per bank, gap cycles, then DONE), and each
// scenario task walks the DUT through a detection event against that list.
// ---------------------------------------------------------------------------
module tb_control_module;

    logic        clk;
    logic        rst;
    logic        por;
    logic        outflag;
    logic        ready;
    logic [3:0]  cfgRepeat;
    logic [3:0]  cfgSelect;
    logic [35:0] cfgSeq;
    logic        cfgSingle;
    logic [4:0]  cfgDelay;
    logic [7:0]  cfgForce;
    logic        cfgPreamb;
    logic        cfgRwp;

    logic        pdEn;
    logic        modEn;
    logic        freqEn;
    logic        modSel;
    logic        anaMuxEn;
    logic        drMuxEn;
    logic [8:0]  selData;
    logic [2:0]  led;

    logic [17:0] got;
    logic [17:0] expQ[$];

    int checkCount = 0;
    int passCount  = 0;

    control_module dut (
        .MAIN_CLK_i                       (clk),
        .MAIN_RST_i                       (rst),
        .FLAG_POR_i                       (por),
        .ADD_PD_OUT_OUTFLAG_i             (outflag),
        .ADD_PD_STA_OUT_READY_i           (ready),
        .CFREG_DATA_BANK_REPEAT_i         (cfgRepeat),
        .CFREG_DATA_BANK_SELECT_i         (cfgSelect),
        .CFREG_DATA_BANK_SEQUENCE_i       (cfgSeq),
        .CFREG_DATA_SEL_SINGLE_SEQUENCE_i (cfgSingle),
        .CFREG_DELAY_DATA_BANK_REPEAT_i   (cfgDelay),
        .CFREG_FORCE_STATE_FSM_i          (cfgForce),
        .CFREG_PREAMB_i                   (cfgPreamb),
        .CFREG_REPEAT_WITH_PREAMB_i       (cfgRwp),
        .ANA_PD_EN_o                      (pdEn),
        .ANA_MOD_EN_o                     (modEn),
        .ANA_FREQ_DIVIDER_EN_o            (freqEn),
        .ANA_INTERFACE_IN_MODSELECT_o     (modSel),
        .ANA_MUX_EN_o                     (anaMuxEn),
        .DATA_REG_MUX_EN_o                (drMuxEn),
        .DATA_REG_MUX_SEL_DATA_o          (selData),
        .PORT_STA_LED_o                   (led)
    );

    assign got = {pdEn, modEn, freqEn, modSel, anaMuxEn, drMuxEn, selData, led};

    // Free-running 100 MHz-style clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs one expected output word in the same order as 'got'.
    function automatic logic [17:0] mk(input logic pd, input logic mo,
                                       input logic fr, input logic ms,
                                       input logic am, input logic dm,
                                       input logic [8:0] sel,
                                       input logic [2:0] ledV);
        return {pd, mo, fr, ms, am, dm, sel, ledV};
    endfunction

    function automatic logic [17:0] expWait();
        return mk(1, 0, 0, 0, 0, 0, 9'h000, 3'b001);
    endfunction

    function automatic logic [17:0] expPreamb();
        return mk(1, 1, 1, 0, 0, 0, 9'h000, 3'b100);
    endfunction

    function automatic logic [17:0] expGap();
        return mk(1, 0, 0, 0, 0, 0, 9'h000, 3'b100);
    endfunction

    function automatic logic [17:0] expDone();
        return mk(1, 0, 0, 0, 0, 0, 9'h000, 3'b000);
    endfunction

    // A data cycle: valid banks light exactly one select bit, anything past
    // bank 8 gives an empty data cycle with the muxes off.
    function automatic logic [17:0] expSend(input logic [3:0] bank);
        logic [8:0] oh;
        oh = '0;
        if (bank > 4'd8) begin
            return mk(1, 1, 1, 1, 0, 0, 9'h000, 3'b100);
        end
        for (int b = 0; b < 9; b++) begin
            oh[b] = (b == int'(bank));
        end
        return mk(1, 1, 1, 1, 1, 1, oh, 3'b100);
    endfunction

    // Reference model: list the banks of one pass, then lay out every pass
    // with its preamble and the gaps between passes, finishing in DONE.
    function automatic void buildTimeline();
        logic [3:0]  banks[$];
        logic [35:0] seqCopy;
        logic [3:0]  nib;
        int          passes;
        expQ.delete();
        if (cfgSingle) begin
            banks.push_back(cfgSelect);
        end else begin
            seqCopy = cfgSeq;
            for (int k = 0; k < 9; k++) begin
                nib = seqCopy[35:32];
                if (nib > 4'd8) break;
                banks.push_back(nib);
                seqCopy = seqCopy << 4;
            end
        end
        passes = int'(cfgRepeat) + 1;
        for (int p = 0; p < passes; p++) begin
            if ((p == 0 && cfgPreamb) || (p > 0 && cfgPreamb && cfgRwp)) begin
                for (int c = 0; c < 8; c++) expQ.push_back(expPreamb());
            end
            if (banks.size() == 0) begin
                expQ.push_back(expSend(4'hF));
            end else begin
                foreach (banks[i]) expQ.push_back(expSend(banks[i]));
            end
            if (p < passes - 1) begin
                for (int d = 0; d < int'(cfgDelay); d++) expQ.push_back(expGap());
            end
        end
        expQ.push_back(expDone());
    endfunction

    // Puts every configuration input into a neutral state.
    task automatic applyStimulus();
        por       = 1'b0;
        outflag   = 1'b0;
        ready     = 1'b0;
        cfgRepeat = 4'd0;
        cfgSelect = 4'd0;
        cfgSeq    = 36'hFFFFFFFFF;
        cfgSingle = 1'b0;
        cfgDelay  = 5'd0;
        cfgForce  = 8'h00;
        cfgPreamb = 1'b0;
        cfgRwp    = 1'b0;
    endtask

    // Reset values, then IDLE for one edge and PD_WAIT on the next.
    task automatic test_reset();
        rst = 1'b1;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (got !== 18'h0) $display("[TB] FAIL reset_value: got %h want %h", got, 18'h0);
        else passCount++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (got !== 18'h0) $display("[TB] FAIL reset_idle: got %h want %h", got, 18'h0);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expWait()) $display("[TB] FAIL reset_pdwait: got %h want %h", got, expWait());
        else passCount++;
    endtask

    // Eight-slot sequence with a terminator in slot 8, no repeats.
    task automatic test_normal_sequence();
        logic [8:0] wantSel[8];
        logic [8:0] selSeen[$];
        wantSel = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h080, 9'h100};
        cfgSingle = 1'b0;
        cfgSeq    = 36'h01234578F;
        cfgRepeat = 4'd0;
        cfgDelay  = 5'd1;
        cfgPreamb = 1'b0;
        buildTimeline();
        @(negedge clk) outflag = 1'b1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== expQ[i]) $display("[TB] FAIL normal cyc %0d: got %h want %h", i, got, expQ[i]);
            else passCount++;
            if (modSel && drMuxEn) selSeen.push_back(selData);
        end
        checkCount++;
        if (selSeen.size() != 8) $display("[TB] FAIL normal_slots: got %0d want 8", selSeen.size());
        else passCount++;
        for (int i = 0; i < 8 && i < selSeen.size(); i++) begin
            checkCount++;
            if (selSeen[i] !== wantSel[i]) $display("[TB] FAIL normal_sel %0d: got %h want %h", i, selSeen[i], wantSel[i]);
            else passCount++;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== expDone()) $display("[TB] FAIL normal_done_hold %0d: got %h want %h", i, got, expDone());
            else passCount++;
        end
        @(negedge clk) outflag = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expWait()) $display("[TB] FAIL normal_rearm: got %h want %h", got, expWait());
        else passCount++;
    endtask

    // Single mode with a valid bank and with an out-of-range bank.
    task automatic test_single();
        logic [3:0] sels[2];
        sels = '{4'd3, 4'hA};
        cfgSingle = 1'b1;
        cfgRepeat = 4'd0;
        cfgPreamb = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cfgSelect = sels[s];
            buildTimeline();
            @(negedge clk) outflag = 1'b1;
            for (int i = 0; i < expQ.size(); i++) begin
                @(posedge clk); #1;
                checkCount++;
                if (got !== expQ[i]) $display("[TB] FAIL single sel=%0d cyc %0d: got %h want %h", sels[s], i, got, expQ[i]);
                else passCount++;
            end
            @(negedge clk) outflag = 1'b0;
            @(posedge clk); #1;
            checkCount++;
            if (got !== expWait()) $display("[TB] FAIL single_rearm: got %h want %h", got, expWait());
            else passCount++;
        end
        cfgSingle = 1'b0;
    endtask

    // Three passes, each preceded by a preamble, gaps of three cycles.
    task automatic test_repeat_preamb();
        int sendCount;
        sendCount = 0;
        cfgSingle = 1'b0;
        cfgSeq    = 36'h0F0000000;
        cfgRepeat = 4'd2;
        cfgDelay  = 5'd3;
        cfgPreamb = 1'b1;
        cfgRwp    = 1'b1;
        buildTimeline();
        @(negedge clk) outflag = 1'b1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== expQ[i]) $display("[TB] FAIL repeat cyc %0d: got %h want %h", i, got, expQ[i]);
            else passCount++;
            if (modSel) sendCount++;
        end
        checkCount++;
        if (sendCount != 3) $display("[TB] FAIL repeat_passes: got %0d want 3", sendCount);
        else passCount++;
        @(negedge clk) outflag = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expWait()) $display("[TB] FAIL repeat_rearm: got %h want %h", got, expWait());
        else passCount++;
        cfgPreamb = 1'b0;
        cfgRwp    = 1'b0;
    endtask

    // Zero delay: the second pass follows the first with no gap cycle.
    task automatic test_back_to_back();
        cfgSingle = 1'b0;
        cfgSeq    = 36'h36FFFFFFF;
        cfgRepeat = 4'd1;
        cfgDelay  = 5'd0;
        cfgPreamb = 1'b0;
        cfgRwp    = 1'b0;
        buildTimeline();
        @(negedge clk) outflag = 1'b1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== expQ[i]) $display("[TB] FAIL b2b cyc %0d: got %h want %h", i, got, expQ[i]);
            else passCount++;
        end
        @(negedge clk) outflag = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expWait()) $display("[TB] FAIL b2b_rearm: got %h want %h", got, expWait());
        else passCount++;
    endtask

    // Invalid force code is ignored, a valid one pins SEND at slot 0, and
    // after release the FSM carries on from SEND.
    task automatic test_force();
        cfgSingle = 1'b1;
        cfgSelect = 4'd5;
        cfgRepeat = 4'd0;
        @(negedge clk) cfgForce = 8'h03;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== expWait()) $display("[TB] FAIL force_ignored %0d: got %h want %h", i, got, expWait());
            else passCount++;
        end
        @(negedge clk) cfgForce = 8'h08;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== expSend(4'd5)) $display("[TB] FAIL force_send %0d: got %h want %h", i, got, expSend(4'd5));
            else passCount++;
        end
        @(negedge clk) cfgForce = 8'h00;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expDone()) $display("[TB] FAIL force_release: got %h want %h", got, expDone());
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expWait()) $display("[TB] FAIL force_rearm: got %h want %h", got, expWait());
        else passCount++;
        cfgSingle = 1'b0;
    endtask

    // Power-on flag in the middle of a sequence returns to IDLE next edge.
    task automatic test_por();
        cfgSingle = 1'b0;
        cfgSeq    = 36'h012345678;
        cfgRepeat = 4'd0;
        cfgPreamb = 1'b0;
        @(negedge clk) outflag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== expSend(4'(i))) $display("[TB] FAIL por_send %0d: got %h want %h", i, got, expSend(4'(i)));
            else passCount++;
        end
        @(negedge clk);
        por     = 1'b1;
        outflag = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (got !== 18'h0) $display("[TB] FAIL por_idle %0d: got %h want %h", i, got, 18'h0);
            else passCount++;
        end
        @(negedge clk) por = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expWait()) $display("[TB] FAIL por_rearm: got %h want %h", got, expWait());
        else passCount++;
    endtask

    // Random configurations checked against the timeline model.
    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            cfgSingle = 1'($urandom_range(0, 1));
            cfgSelect = 4'($urandom_range(0, 11));
            for (int k = 0; k < 9; k++) cfgSeq[35 - 4 * k -: 4] = 4'($urandom_range(0, 10));
            cfgRepeat = 4'($urandom_range(0, 3));
            cfgDelay  = 5'($urandom_range(0, 4));
            cfgPreamb = 1'($urandom_range(0, 1));
            cfgRwp    = 1'($urandom_range(0, 1));
            buildTimeline();
            @(negedge clk) outflag = 1'b1;
            for (int i = 0; i < expQ.size(); i++) begin
                @(posedge clk); #1;
                checkCount++;
                if (got !== expQ[i]) $display("[TB] FAIL random it %0d cyc %0d: got %h want %h", it, i, got, expQ[i]);
                else passCount++;
            end
            @(posedge clk); #1;
            checkCount++;
            if (got !== expDone()) $display("[TB] FAIL random_done_hold it %0d: got %h want %h", it, got, expDone());
            else passCount++;
            @(negedge clk) outflag = 1'b0;
            @(posedge clk); #1;
            checkCount++;
            if (got !== expWait()) $display("[TB] FAIL random_rearm it %0d: got %h want %h", it, got, expWait());
            else passCount++;
        end
        applyStimulus();
    endtask

    // Reset asserted between edges in GAP; outputs drop without a clock.
    // Ready is then raised and shows on LED[1] one edge after release.
    task automatic test_async_reset();
        cfgSingle = 1'b1;
        cfgSelect = 4'd2;
        cfgRepeat = 4'd1;
        cfgDelay  = 5'd5;
        cfgPreamb = 1'b0;
        @(negedge clk) outflag = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expSend(4'd2)) $display("[TB] FAIL async_send: got %h want %h", got, expSend(4'd2));
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (got !== expGap()) $display("[TB] FAIL async_gap: got %h want %h", got, expGap());
        else passCount++;
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if (got !== 18'h0) $display("[TB] FAIL async_reset_out: got %h want %h", got, 18'h0);
        else passCount++;
        outflag = 1'b0;
        ready   = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        checkCount++;
        if (led !== 3'b000) $display("[TB] FAIL async_led_before: got %b want %b", led, 3'b000);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (got !== mk(0, 0, 0, 0, 0, 0, 9'h000, 3'b010)) $display("[TB] FAIL async_ready_led: got %h want %h", got, mk(0, 0, 0, 0, 0, 0, 9'h000, 3'b010));
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (got !== mk(1, 0, 0, 0, 0, 0, 9'h000, 3'b011)) $display("[TB] FAIL async_rearm: got %h want %h", got, mk(1, 0, 0, 0, 0, 0, 9'h000, 3'b011));
        else passCount++;
        ready = 1'b0;
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_normal_sequence();
        test_single();
        test_repeat_preamb();
        test_back_to_back();
        test_force();
        test_por();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
